// File: rtl/array_copy.sv
// Bulk copy initiator: reads `count` elements from the source array port and writes
// them to the destination array port, then returns the count and a wrapping checksum.
module array_copy #(
  parameter int addrN = 8,
  parameter int intN  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [addrN-1:0] src_base,
  input  logic [addrN-1:0] dst_base,
  input  logic [intN-1:0]  count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [intN-1:0]  copied,
  output logic [intN-1:0]  sum,
  output logic [addrN-1:0] src_addr,
  output logic             src_we,
  output logic [intN-1:0]  src_di,
  input  logic [intN-1:0]  src_do,
  output logic             src_valid,
  input  logic             src_ready,
  output logic [addrN-1:0] dst_addr,
  output logic             dst_we,
  output logic [intN-1:0]  dst_di,
  input  logic [intN-1:0]  dst_do,
  output logic             dst_valid,
  input  logic             dst_ready
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef struct packed {
    logic [addrN-1:0] src_base;
    logic [addrN-1:0] dst_base;
    logic [intN-1:0]  count;
  } req_t;

  state_t          state;
  req_t            req_q;
  logic [intN-1:0] idx;
  logic [intN-1:0] idx_nxt;

  assign idx_nxt  = idx + 1'b1;
  assign in_ready = (state == IDLE) && !reset;
  assign src_we   = 1'b0;
  assign src_di   = '0;

  // Destination read data has no use in a copy.
  logic unused_dst_do;
  assign unused_dst_do = ^dst_do;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      copied    <= '0;
      sum       <= '0;
      src_valid <= 1'b0;
      src_addr  <= '0;
      dst_valid <= 1'b0;
      dst_we    <= 1'b0;
      dst_addr  <= '0;
      dst_di    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          req_q <= '{src_base: src_base, dst_base: dst_base, count: count};
          idx   <= '0;
          sum   <= '0;
          if (count == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            copied    <= '0;
          end else begin
            state     <= READ;
            src_valid <= 1'b1;
            src_addr  <= src_base;
          end
        end
        READ: if (src_ready) begin
          // dst_di doubles as the data register between the read and the write.
          dst_di    <= src_do;
          sum       <= sum + src_do;
          src_valid <= 1'b0;
          dst_valid <= 1'b1;
          dst_we    <= 1'b1;
          dst_addr  <= req_q.dst_base + addrN'(idx);
          state     <= WRITE;
        end
        WRITE: if (dst_ready) begin
          idx       <= idx_nxt;
          dst_valid <= 1'b0;
          dst_we    <= 1'b0;
          if (idx_nxt == req_q.count) begin
            state     <= DONE;
            out_valid <= 1'b1;
            copied    <= req_q.count;
          end else begin
            state     <= READ;
            src_valid <= 1'b1;
            src_addr  <= req_q.src_base + addrN'(idx_nxt);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_copy.sv
// Bench for array_copy: memory-backed responders, table of copy requests, scoreboard
// of expected results, plus hand sequences for result back-pressure and mid-copy reset.
module tb_array_copy;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] src_base, dst_base, count, copied, sum;
  logic [7:0] src_addr, src_di, src_do, dst_addr, dst_di, dst_do;
  logic       src_we, src_valid, src_ready, dst_we, dst_valid, dst_ready;

  always #5 clk = ~clk;

  array_copy #(.addrN(8), .intN(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src_base(src_base), .dst_base(dst_base), .count(count),
    .out_valid(out_valid), .out_ready(out_ready), .copied(copied), .sum(sum),
    .src_addr(src_addr), .src_we(src_we), .src_di(src_di), .src_do(src_do),
    .src_valid(src_valid), .src_ready(src_ready),
    .dst_addr(dst_addr), .dst_we(dst_we), .dst_di(dst_di), .dst_do(dst_do),
    .dst_valid(dst_valid), .dst_ready(dst_ready)
  );

  // Responders: src_wait_cfg stalls every read, dst_wait_cfg stalls only the first write.
  logic [7:0] src_mem [256];
  logic [7:0] dst_mem [256];
  int swait = 0, dwait = 0, src_wait_cfg = 0, dst_wait_cfg = 0;
  logic dst_done = 1'b0;

  assign src_do    = src_mem[src_addr];
  assign dst_do    = 8'h00;
  assign src_ready = src_valid && (swait >= src_wait_cfg);
  assign dst_ready = dst_valid && (dst_done || dwait >= dst_wait_cfg);

  always @(posedge clk) begin
    swait <= (src_valid && !src_ready) ? swait + 1 : 0;
    dwait <= (dst_valid && !dst_ready) ? dwait + 1 : 0;
    if (dst_valid && dst_ready) begin
      dst_done <= 1'b1;
      if (dst_we) dst_mem[dst_addr] <= dst_di;
    end
    if (in_valid && in_ready) dst_done <= 1'b0;
  end

  // Protocol monitor: no overlap of requests, stalled requests hold steady.
  int viol = 0, wr_cnt = 0, req_cyc = 0;
  logic       dpend = 1'b0, spend = 1'b0;
  logic [7:0] p_daddr = '0, p_ddi = '0, p_saddr = '0;
  logic [7:0] saddr_log [$];

  always @(negedge clk) begin
    if (!reset) begin
      if (src_valid && dst_valid) viol <= viol + 1;
      if (dpend && (!dst_valid || !dst_we || dst_addr != p_daddr || dst_di != p_ddi)) viol <= viol + 1;
      if (spend && (!src_valid || src_addr != p_saddr)) viol <= viol + 1;
      if (src_we) viol <= viol + 1;
      if (src_valid && src_ready) saddr_log.push_back(src_addr);
      if (dst_valid && dst_ready) wr_cnt <= wr_cnt + 1;
      if (src_valid || dst_valid) req_cyc <= req_cyc + 1;
    end
    dpend   <= dst_valid && !dst_ready;
    spend   <= src_valid && !src_ready;
    p_daddr <= dst_addr;
    p_ddi   <= dst_di;
    p_saddr <= src_addr;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct { int sb, db, cnt, sw, dw, oh, es; } vec_t;
  typedef struct { int cnt, sum; } res_t;
  res_t sb_q [$];

  task automatic run_vec(input vec_t v);
    int lat, exp_lat, es, wr0, req0, viol0, bad, tries;
    es = 0;
    for (int k = 0; k < v.cnt; k++) es += src_mem[(v.sb + k) % 256];
    es = (v.es >= 0) ? v.es : es % 256;
    src_wait_cfg = v.sw;
    dst_wait_cfg = v.dw;
    wr0 = wr_cnt; req0 = req_cyc; viol0 = viol;
    tries = 0;
    @(negedge clk);
    while (!in_ready && tries < 10) begin @(negedge clk); tries++; end
    chk("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1; src_base = v.sb[7:0]; dst_base = v.db[7:0]; count = v.cnt[7:0];
    sb_q.push_back('{v.cnt, es});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    exp_lat = 2 * v.cnt + 1 + ((v.cnt > 0) ? v.dw : 0) + v.cnt * v.sw;
    chk("latency", lat, exp_lat);
    // Back-pressure on the result while a competing request is offered.
    for (int h = 0; h < v.oh; h++) begin
      @(negedge clk);
      in_valid = 1'b1; count = 8'd5;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_copied", copied, sb_q[0].cnt);
      chk("hold_sum", sum, sb_q[0].sum);
      chk("hold_no_src_req", src_valid, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    if (sb_q.size() > 0) begin
      chk("copied", copied, sb_q[0].cnt);
      chk("sum", sum, sb_q[0].sum);
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("write_count", wr_cnt - wr0, v.cnt);
    if (v.cnt == 0) chk("no_requests_cnt0", req_cyc - req0, 0);
    chk("protocol_viol", viol - viol0, 0);
    bad = 0;
    for (int k = 0; k < v.cnt; k++)
      if (dst_mem[(v.db + k) % 256] != src_mem[(v.sb + k) % 256]) bad++;
    chk("dst_contents_bad", bad, 0);
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, wait_n, seen;
    vecs[0] = '{3, 8, 4, 0, 0, 0, 100};
    vecs[1] = '{3, 8, 0, 0, 0, 0, 0};
    vecs[2] = '{254, 0, 3, 0, 0, 0, 51};
    vecs[3] = '{3, 20, 2, 0, 3, 0, 30};
    vecs[4] = '{3, 30, 1, 0, 0, 5, 10};
    vecs[5] = '{100, 128, 17, 1, 0, 0, -1};
    vecs[6] = '{250, 250, 10, 0, 0, 0, -1};
    vecs[7] = '{0, 60, 255, 0, 0, 0, -1};
    for (int a = 0; a < 256; a++) begin
      src_mem[a] = 8'((a * 7 + 3) % 256);
      dst_mem[a] = 8'h00;
    end
    src_mem[3] = 10; src_mem[4] = 20; src_mem[5] = 30; src_mem[6] = 40;
    src_mem[254] = 200; src_mem[255] = 100; src_mem[0] = 7;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src_base = '0; dst_base = '0; count = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_copied", copied, 0);
    chk("rst_sum", sum, 0);
    chk("rst_valids", {src_valid, dst_valid}, 0);
    chk("rst_we", {src_we, dst_we}, 0);
    chk("rst_addrs", {src_addr, dst_addr}, 0);
    chk("rst_di", {src_di, dst_di}, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (i == 2) begin
        n = saddr_log.size();
        chk("wrap_src_addr0", saddr_log[n-3], 254);
        chk("wrap_src_addr1", saddr_log[n-2], 255);
        chk("wrap_src_addr2", saddr_log[n-1], 0);
      end
    end

    // Reset during the write of element 1 of a four-element copy.
    src_wait_cfg = 0; dst_wait_cfg = 0;
    n = wr_cnt;
    @(negedge clk);
    in_valid = 1'b1; src_base = 8'd3; dst_base = 8'd40; count = 8'd4;
    @(negedge clk);
    in_valid = 1'b0;
    wait_n = 0;
    while (!(dst_valid && wr_cnt == n + 1) && wait_n < 50) begin @(negedge clk); wait_n++; end
    chk("reached_write1", dst_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_src_valid", src_valid, 0);
    chk("abort_dst_valid", dst_valid, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("abort_idle_in_ready", in_ready, 1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || src_valid || dst_valid) seen++;
    end
    chk("abort_no_activity", seen, 0);
    chk("abort_elem0_kept", dst_mem[40], 10);
    run_vec('{3, 70, 4, 0, 0, 0, 100});

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
